// File: rtl/nfca_pkg.sv
// nfca_pkg: shared state encoding and CRC_A constants for the NFC-A transmit path.
package nfca_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_SOF, ST_DATA, ST_PAR, ST_CRC_LO, ST_CRC_HI, ST_EOF, ST_STOP
  } nfca_tx_state_t;
  localparam logic [15:0] NFCA_CRC_INIT = 16'h6363;
  localparam logic [15:0] NFCA_CRC_POLY = 16'h8408;
endpackage

// File: rtl/nfca_crc_a.sv
// nfca_crc_a: bit-serial CRC_A register (reflected 0x1021, preset 0x6363, LSB-first bits).
module nfca_crc_a
  import nfca_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        init,
  input  logic        bit_en,
  input  logic        din,
  output logic [15:0] crc
);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) crc <= NFCA_CRC_INIT;
    else if (init) crc <= NFCA_CRC_INIT;
    else if (bit_en) crc <= (crc >> 1) ^ ((crc[0] ^ din) ? NFCA_CRC_POLY : 16'h0000);
endmodule

// File: rtl/nfca_tx_sequencer.sv
// nfca_tx_sequencer: NFC-A PCD frame builder (SOF, LSB-first data, odd parity, CRC_A, EOF) paced by modulator bit requests.
// CRC_A append is compiled in only when NFCA_TX_CRC_EN is defined.
module nfca_tx_sequencer
  import nfca_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_tvalid,
  output logic       tx_tready,
  input  logic [7:0] tx_tdata,
  input  logic       tx_tlast,
  input  logic [2:0] tx_tbits,
  input  logic       tx_crc,
  input  logic       tx_req,
  output logic       tx_en,
  output logic       tx_bit,
  output logic       busy,
  output logic       done,
  output logic       underrun
);
  nfca_tx_state_t state;
  logic [7:0] hold_data, shift;
  logic [2:0] hold_tbits, cur_tbits, cnt;
  logic [1:0] seg;
  logic [15:0] crc;
  logic hold_full, hold_last, cur_last, closed, discard, crc_en, fin, crc_req;
  logic accept, short_end, more, underrun_now, load_hold;
  // once the frame's last byte is in, the next frame waits for IDLE
  assign tx_tready = ~hold_full & ~closed;
  assign busy = state != ST_IDLE;
  assign accept = tx_tvalid & tx_tready;
  assign short_end = cur_last && cur_tbits != 3'd0 && cnt == cur_tbits - 3'd1;
  assign more = tx_req && state == ST_PAR && seg == 2'd0 && !cur_last;
  assign underrun_now = more && !hold_full;
  assign load_hold = (tx_req && state == ST_SOF) || (more && hold_full);
`ifdef NFCA_TX_CRC_EN
  nfca_crc_a u_crc (
    .clk(clk),
    .rstn(rstn),
    .init(tx_req && state == ST_SOF),
    .bit_en(tx_req && state == ST_DATA),
    .din(shift[cnt]),
    .crc(crc)
  );
  assign crc_req = tx_crc;
`else
  logic unused_crc;
  assign unused_crc = tx_crc;
  assign crc = NFCA_CRC_INIT;
  assign crc_req = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= ST_IDLE;
      hold_data <= 8'h00; hold_tbits <= 3'd0; hold_last <= 1'b0; hold_full <= 1'b0;
      shift <= 8'h00; cur_tbits <= 3'd0; cur_last <= 1'b0; cnt <= 3'd0; seg <= 2'd0;
      closed <= 1'b0; discard <= 1'b0; crc_en <= 1'b0; fin <= 1'b0;
      tx_en <= 1'b0; tx_bit <= 1'b0; done <= 1'b0; underrun <= 1'b0;
    end else begin
      done <= 1'b0;
      underrun <= underrun_now;
      if (underrun_now) discard <= 1'b1;
      if (accept && tx_tlast) closed <= 1'b1;
      if (accept && !discard && !underrun_now) begin
        hold_full <= 1'b1; hold_data <= tx_tdata; hold_last <= tx_tlast; hold_tbits <= tx_tbits;
      end
      if (load_hold) begin
        hold_full <= 1'b0; shift <= hold_data; cur_last <= hold_last; cur_tbits <= hold_tbits;
        cnt <= 3'd0; seg <= 2'd0;
      end
      case (state)
        ST_IDLE: if (accept) begin state <= ST_SOF; crc_en <= crc_req; end
        ST_SOF: if (tx_req) begin tx_en <= 1'b1; tx_bit <= 1'b0; state <= ST_DATA; end
        ST_DATA, ST_CRC_LO, ST_CRC_HI: if (tx_req) begin
          tx_bit <= shift[cnt];
          cnt <= cnt + 3'd1;
          if (state == ST_DATA && short_end) state <= ST_EOF;
          else if (cnt == 3'd7) state <= ST_PAR;
        end
        ST_PAR: if (tx_req) begin
          tx_bit <= ~^shift;
          if (seg == 2'd1) begin
            shift <= crc[15:8]; cnt <= 3'd0; seg <= 2'd2; state <= ST_CRC_HI;
          end else if (seg == 2'd2 || (cur_last && !crc_en) || underrun_now) state <= ST_EOF;
          else if (cur_last) begin
            shift <= crc[7:0]; cnt <= 3'd0; seg <= 2'd1; state <= ST_CRC_LO;
          end else state <= ST_DATA;
        end
        ST_EOF: if (tx_req) begin tx_bit <= 1'b0; state <= ST_STOP; end
        ST_STOP:
          if (fin) begin
            fin <= 1'b0; done <= 1'b1; closed <= 1'b0; discard <= 1'b0; state <= ST_IDLE;
          end else if (tx_req) begin
            tx_en <= 1'b0; tx_bit <= 1'b0; fin <= 1'b1;
          end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_nfca_tx_sequencer.sv
// tb_nfca_tx_sequencer: randomized bench comparing the transmitted bitstream with a frame-level NFC-A model.
module tb_nfca_tx_sequencer;
  localparam int REQ_GAP = 16;
`ifdef NFCA_TX_CRC_EN
  localparam bit HAS_CRC = 1'b1;
`else
  localparam bit HAS_CRC = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b1;
  logic tx_tvalid = 1'b0, tx_tlast = 1'b0, tx_crc = 1'b0, tx_req = 1'b0;
  logic [7:0] tx_tdata = 8'h00;
  logic [2:0] tx_tbits = 3'd0;
  logic tx_tready, tx_en, tx_bit, busy, done, underrun;
  int n_pass = 0, n_total = 0;
  logic [7:0] frm[$];
  int frm_tbits = 0;
  bit frm_crc = 1'b0;
  bit exp_q[$];

  always #5 clk = ~clk;

  nfca_tx_sequencer dut (
    .clk(clk), .rstn(rstn), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .tx_tdata(tx_tdata), .tx_tlast(tx_tlast), .tx_tbits(tx_tbits), .tx_crc(tx_crc),
    .tx_req(tx_req), .tx_en(tx_en), .tx_bit(tx_bit), .busy(busy), .done(done),
    .underrun(underrun)
  );

  // Expected on-air bit list for frm: SOF, data (+parity per full byte), optional CRC bytes, EOF.
  function automatic void build_exp();
    logic [15:0] c;
    logic [7:0] b;
    int nb;
    c = 16'h6363;
    exp_q = {};
    exp_q.push_back(1'b0);
    for (int i = 0; i < frm.size(); i++) begin
      b = frm[i];
      nb = (i == frm.size() - 1 && frm_tbits != 0) ? frm_tbits : 8;
      for (int k = 0; k < nb; k++) begin
        exp_q.push_back(b[k]);
        c = {1'b0, c[15:1]} ^ ((c[0] ^ b[k]) ? 16'h8408 : 16'h0000);
      end
      if (nb == 8) exp_q.push_back(~^b);
    end
    if (HAS_CRC && frm_crc && frm_tbits == 0)
      for (int j = 0; j < 2; j++) begin
        b = (j == 0) ? c[7:0] : c[15:8];
        for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
        exp_q.push_back(~^b);
      end
    exp_q.push_back(1'b0);
  endfunction

  task automatic push_byte(input logic [7:0] d, input logic last, input logic [2:0] tb, input logic crc);
    int t = 0;
    tx_tvalid = 1'b1; tx_tdata = d; tx_tlast = last; tx_tbits = tb; tx_crc = crc;
    while (!tx_tready && t < 4000) begin @(negedge clk); t++; end
    @(negedge clk);
    n_total++;
    if (t >= 4000) $display("FAIL push: byte %h not accepted, tready=%b want 1", d, tx_tready);
    else n_pass++;
  endtask

  task automatic host_send(input bit release_valid);
    for (int i = 0; i < frm.size(); i++)
      push_byte(frm[i], i == frm.size() - 1,
                (i == frm.size() - 1) ? 3'(frm_tbits) : 3'($urandom),
                (i == 0) ? frm_crc : 1'($urandom));
    if (release_valid) tx_tvalid = 1'b0;
  endtask

  task automatic check_frame(input string name);
    int n = exp_q.size();
    for (int i = 0; i <= n; i++) begin
      repeat (REQ_GAP) @(negedge clk);
      tx_req = 1'b1;
      @(negedge clk);
      tx_req = 1'b0;
      n_total++;
      if (tx_en !== (i < n) || (i < n && tx_bit !== exp_q[i]) || busy !== 1'b1)
        $display("FAIL %s req %0d: got en=%b bit=%b busy=%b, want en=%b bit=%b busy=1",
                 name, i, tx_en, tx_bit, busy, i < n, (i < n) ? exp_q[i] : 1'b0);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (done !== 1'b1 || busy !== 1'b0 || tx_tready !== 1'b1)
      $display("FAIL %s end: got done=%b busy=%b tready=%b, want 1 0 1", name, done, busy, tx_tready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0) $display("FAIL %s done width: got done=%b, want 0", name, done);
    else n_pass++;
  endtask

  task automatic run_frame(input string name);
    build_exp();
    fork
      host_send(1'b1);
      check_frame(name);
    join
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (tx_en !== 1'b0 || tx_bit !== 1'b0) $display("FAIL reset datapath: en=%b bit=%b, want 0 0", tx_en, tx_bit);
    else n_pass++;
    n_total++;
    if (tx_tready !== 1'b1 || busy !== 1'b0) $display("FAIL reset handshake: tready=%b busy=%b, want 1 0", tx_tready, busy);
    else n_pass++;
    n_total++;
    if (done !== 1'b0 || underrun !== 1'b0) $display("FAIL reset pulses: done=%b underrun=%b, want 0 0", done, underrun);
    else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reqa(input string name);
    frm = {8'h26}; frm_tbits = 7; frm_crc = 1'b1;
    run_frame(name);
  endtask

  task automatic test_hlta();
    frm = {8'h50, 8'h00}; frm_tbits = 0; frm_crc = 1'b1;
    run_frame("hlta");
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int n = $urandom_range(1, 4);
      frm = {};
      for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
      frm_tbits = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
      frm_crc = 1'($urandom);
      run_frame($sformatf("rand%0d", f));
    end
  endtask

  task automatic test_underrun();
    int t = 0;
    frm = {8'hC3}; frm_tbits = 0; frm_crc = 1'b0;
    build_exp();
    fork
      begin
        push_byte(8'hC3, 1'b0, 3'd0, 1'b0);
        tx_tvalid = 1'b0;
        while (!underrun && t < 4000) begin @(negedge clk); t++; end
        n_total++;
        if (t >= 4000) $display("FAIL underrun pulse: underrun=%b, want 1", underrun);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (underrun !== 1'b0) $display("FAIL underrun width: underrun=%b, want 0", underrun);
        else n_pass++;
        push_byte(8'h11, 1'b0, 3'd0, 1'b0);
        push_byte(8'h22, 1'b1, 3'd0, 1'b0);
        tx_tvalid = 1'b0;
      end
      check_frame("underrun");
    join
  endtask

  task automatic test_reset_mid();
    frm = {8'hA5, 8'h3C}; frm_tbits = 0; frm_crc = 1'b1;
    build_exp();
    fork
      host_send(1'b1);
      for (int i = 0; i < 13; i++) begin
        repeat (REQ_GAP) @(negedge clk);
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        n_total++;
        if (tx_en !== 1'b1 || tx_bit !== exp_q[i])
          $display("FAIL pre_reset req %0d: got en=%b bit=%b, want en=1 bit=%b", i, tx_en, tx_bit, exp_q[i]);
        else n_pass++;
      end
    join
    #2 rstn = 1'b0;
    #1;
    n_total++;
    if (tx_en !== 1'b0 || busy !== 1'b0 || tx_tready !== 1'b1)
      $display("FAIL mid reset: en=%b busy=%b tready=%b, want 0 0 1", tx_en, busy, tx_tready);
    else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    frm = {8'h50, 8'h00}; frm_tbits = 0; frm_crc = 1'b1;
    run_frame("post_reset_hlta");
  endtask

  task automatic test_back_to_back();
    bit ea[$], eb[$];
    logic [7:0] fa[$], fb[$];
    int tb_b;
    bit crc_b;
    fa = {8'h93, 8'h20};
    frm = fa; frm_tbits = 0; frm_crc = 1'b0;
    build_exp(); ea = exp_q;
    fb = {8'($urandom), 8'($urandom), 8'($urandom)};
    tb_b = 0; crc_b = 1'b1;
    frm = fb; frm_tbits = tb_b; frm_crc = crc_b;
    build_exp(); eb = exp_q;
    fork
      begin
        frm = fa; frm_tbits = 0; frm_crc = 1'b0;
        host_send(1'b0);
        frm = fb; frm_tbits = tb_b; frm_crc = crc_b;
        host_send(1'b1);
      end
      begin
        exp_q = ea;
        check_frame("b2b_a");
        n_total++;
        if (tx_tready !== 1'b0 || busy !== 1'b1)
          $display("FAIL b2b restart: tready=%b busy=%b, want 0 1", tx_tready, busy);
        else n_pass++;
        exp_q = eb;
        check_frame("b2b_b");
      end
    join
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_reqa("reqa");
    test_hlta();
    test_random();
    test_underrun();
    test_reqa("reqa_after_underrun");
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
